// File: rtl/mood_pkg.sv
// Shared definitions for the mood-logic level trackers: level encoding and
// quarter/threshold helpers for hysteretic level FSMs.
package mood_pkg;

   localparam logic [1:0] LEVEL_EMPTY = 2'd0;
   localparam logic [1:0] LEVEL_LOW   = 2'd1;
   localparam logic [1:0] LEVEL_OK    = 2'd2;
   localparam logic [1:0] LEVEL_FULL  = 2'd3;

   typedef enum logic [1:0] {
      L0 = LEVEL_EMPTY,
      L1 = LEVEL_LOW,
      L2 = LEVEL_OK,
      L3 = LEVEL_FULL
   } level_t;

   function automatic int quarter_size(input int acc_width);
      return 1 << (acc_width - 2);
   endfunction

   // Accumulator value at or above which level k moves up to k+1.
   function automatic int up_threshold(input int level, input int q, input int hyst);
      return (level + 1) * q + hyst;
   endfunction

   // Accumulator value below which level k moves down to k-1 (k > 0 only).
   function automatic int down_threshold(input int level, input int q, input int hyst);
      return level * q - hyst;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running enable-gated prescaler: one tick every PRESCALE enabled cycles.
module tick_prescaler #(
   parameter int PRESCALE = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   output logic tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] count;

   assign tick = ena && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (ena) begin
         if (count == LAST) count <= '0;
         else               count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/nourishment_level_tracker.sv
// Integrates regulator inc/dec/fast/setval commands into a saturating
// accumulator and publishes a hysteretic 2-bit nourishment level.
module nourishment_level_tracker
   import mood_pkg::*;
#(
   parameter int ACC_WIDTH   = 10,
   parameter int PRESCALE    = 16,
   parameter int SLOW_STEP   = 1,
   parameter int FAST_STEP   = 4,
   parameter int SET_VALUE   = 640,
   parameter int RESET_VALUE = 768,
   parameter int HYST        = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic                 inc,
   input  logic                 dec,
   input  logic                 fast,
   input  logic                 setval,
   output logic [1:0]           level,
   output logic [ACC_WIDTH-1:0] acc,
   output logic                 level_changed,
   output logic                 at_min,
   output logic                 at_max
);

   localparam int Q     = quarter_size(ACC_WIDTH);
   localparam int EW    = ACC_WIDTH + 1;
   localparam logic [EW-1:0] MAX_EXT  = {1'b0, {ACC_WIDTH{1'b1}}};
   localparam logic [EW-1:0] SLOW_EXT = EW'(SLOW_STEP);
   localparam logic [EW-1:0] FAST_EXT = EW'(FAST_STEP);
   localparam logic [ACC_WIDTH-1:0] SET_ACC   = ACC_WIDTH'(SET_VALUE);
   localparam logic [ACC_WIDTH-1:0] RESET_ACC = ACC_WIDTH'(RESET_VALUE);
   localparam logic [1:0] RESET_LEVEL = 2'(RESET_VALUE >> (ACC_WIDTH - 2));

   logic           tick;
   level_t         level_q;
   logic [EW-1:0]  acc_ext, step_ext, sum, diff, up_thr, dn_thr;
   logic [ACC_WIDTH-1:0] acc_up, acc_dn;
   logic [1:0]     lvl_up, lvl_dn;

   tick_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .tick (tick)
   );

   // Arithmetic is one bit wider than the accumulator so we clamp, never wrap.
   always_comb begin
      acc_ext  = {1'b0, acc};
      step_ext = fast ? FAST_EXT : SLOW_EXT;
      sum      = acc_ext + step_ext;
      diff     = acc_ext - step_ext;
      acc_up   = (sum > MAX_EXT) ? MAX_EXT[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
      acc_dn   = (acc_ext < step_ext) ? '0 : diff[ACC_WIDTH-1:0];
      up_thr   = EW'(up_threshold(int'(level_q), Q, HYST));
      dn_thr   = EW'(down_threshold(int'(level_q), Q, HYST));
      lvl_up   = level_q + 2'd1;
      lvl_dn   = level_q - 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= RESET_ACC;
      end else if (tick) begin
         if (setval && (level_q == L0 || level_q == L1)) acc <= SET_ACC;
         else if (inc && !dec)                          acc <= acc_up;
         else if (dec && !inc)                          acc <= acc_dn;
      end
   end

   // Level FSM: at most one step per enabled cycle, pulse marks each update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_q       <= level_t'(RESET_LEVEL);
         level_changed <= 1'b0;
      end else if (!ena) begin
         level_changed <= 1'b0;
      end else if (level_q != L3 && acc_ext >= up_thr) begin
         level_q       <= level_t'(lvl_up);
         level_changed <= 1'b1;
      end else if (level_q != L0 && acc_ext < dn_thr) begin
         level_q       <= level_t'(lvl_dn);
         level_changed <= 1'b1;
      end else begin
         level_changed <= 1'b0;
      end
   end

   assign level  = level_q;
   assign at_min = (acc == '0);
   assign at_max = (acc == {ACC_WIDTH{1'b1}});

endmodule

// File: tb/tb_nourishment_level_tracker.sv
// Directed self-checking bench for nourishment_level_tracker (PRESCALE=4, Q=256).
module tb_nourishment_level_tracker;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          ena, inc, dec, fast, setval;
   logic [1:0]    level;
   logic [AW-1:0] acc;
   logic          level_changed, at_min, at_max;

   int checks = 0;
   int errors = 0;
   int ph     = 0;

   nourishment_level_tracker #(.PRESCALE(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .ena           (ena),
      .inc           (inc),
      .dec           (dec),
      .fast          (fast),
      .setval        (setval),
      .level         (level),
      .acc           (acc),
      .level_changed (level_changed),
      .at_min        (at_min),
      .at_max        (at_max)
   );

   always #5 clk = ~clk;

   // Advance n clock edges, sampling 1 time unit after each; ph tracks the
   // expected prescaler phase.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (ena) ph = (ph + 1) % 4;
      end
   endtask

   task automatic align();
      while (ph != 0) step(1);
   endtask

   task automatic cmd(input logic i, input logic d, input logic f, input logic s);
      inc = i; dec = d; fast = f; setval = s;
   endtask

   task automatic test_reset();
      rst = 1'b1; ena = 1'b1; cmd(1'b0, 1'b1, 1'b0, 1'b0);
      #12;
      checks++; if (acc !== 10'd768) begin errors++; $display("FAIL reset_acc: got %0d expected 768", acc); end
      checks++; if (level !== 2'd3) begin errors++; $display("FAIL reset_level: got %0d expected 3", level); end
      checks++; if (level_changed !== 1'b0) begin errors++; $display("FAIL reset_lc: got %b expected 0", level_changed); end
      checks++; if (at_min !== 1'b0 || at_max !== 1'b0) begin errors++; $display("FAIL reset_flags: got min=%b max=%b expected 0 0", at_min, at_max); end
      rst = 1'b0; ph = 0;
   endtask

   task automatic test_dec_hysteresis();
      step(3);
      checks++; if (acc !== 10'd768) begin errors++; $display("FAIL first_tick_pre: got %0d expected 768", acc); end
      step(1);
      checks++; if (acc !== 10'd767) begin errors++; $display("FAIL first_tick: got %0d expected 767", acc); end
      step(28);
      checks++; if (acc !== 10'd760 || level !== 2'd3) begin errors++; $display("FAIL dec_760: got acc=%0d lvl=%0d expected 760 3", acc, level); end
      step(4);
      checks++; if (acc !== 10'd759 || level !== 2'd3 || level_changed !== 1'b0) begin errors++; $display("FAIL dec_759: got acc=%0d lvl=%0d lc=%b expected 759 3 0", acc, level, level_changed); end
      step(1);
      checks++; if (level !== 2'd2 || level_changed !== 1'b1) begin errors++; $display("FAIL dec_level2: got lvl=%0d lc=%b expected 2 1", level, level_changed); end
      step(1);
      checks++; if (level !== 2'd2 || level_changed !== 1'b0) begin errors++; $display("FAIL dec_pulse_end: got lvl=%0d lc=%b expected 2 0", level, level_changed); end
   endtask

   task automatic test_inc_hysteresis();
      cmd(1'b0, 1'b0, 1'b0, 1'b0);
      align();
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      step(64);
      checks++; if (acc !== 10'd775 || level !== 2'd2) begin errors++; $display("FAIL inc_775: got acc=%0d lvl=%0d expected 775 2", acc, level); end
      step(4);
      checks++; if (acc !== 10'd776 || level !== 2'd2) begin errors++; $display("FAIL inc_776: got acc=%0d lvl=%0d expected 776 2", acc, level); end
      step(1);
      checks++; if (level !== 2'd3 || level_changed !== 1'b1) begin errors++; $display("FAIL inc_level3: got lvl=%0d lc=%b expected 3 1", level, level_changed); end
      cmd(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_saturation();
      align();
      cmd(1'b1, 1'b0, 1'b1, 1'b0);
      step(61 * 4);
      cmd(1'b1, 1'b0, 1'b0, 1'b0);
      step(4);
      checks++; if (acc !== 10'd1021) begin errors++; $display("FAIL sat_1021: got %0d expected 1021", acc); end
      cmd(1'b1, 1'b0, 1'b1, 1'b0);
      step(4);
      checks++; if (acc !== 10'd1023 || at_max !== 1'b1) begin errors++; $display("FAIL sat_max: got acc=%0d max=%b expected 1023 1", acc, at_max); end
      step(4);
      checks++; if (acc !== 10'd1023 || at_max !== 1'b1) begin errors++; $display("FAIL sat_max_hold: got acc=%0d max=%b expected 1023 1", acc, at_max); end
      cmd(1'b0, 1'b1, 1'b1, 1'b0);
      step(255 * 4);
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      step(4);
      checks++; if (acc !== 10'd2 || at_min !== 1'b0) begin errors++; $display("FAIL sat_2: got acc=%0d min=%b expected 2 0", acc, at_min); end
      cmd(1'b0, 1'b1, 1'b1, 1'b0);
      step(4);
      checks++; if (acc !== 10'd0 || at_min !== 1'b1) begin errors++; $display("FAIL sat_min: got acc=%0d min=%b expected 0 1", acc, at_min); end
      step(4);
      checks++; if (acc !== 10'd0 || at_min !== 1'b1 || level !== 2'd0) begin errors++; $display("FAIL sat_min_hold: got acc=%0d min=%b lvl=%0d expected 0 1 0", acc, at_min, level); end
   endtask

   task automatic test_setval();
      cmd(1'b1, 1'b0, 1'b1, 1'b0);
      step(75 * 4);
      checks++; if (acc !== 10'd300 || level !== 2'd1) begin errors++; $display("FAIL set_pre: got acc=%0d lvl=%0d expected 300 1", acc, level); end
      cmd(1'b1, 1'b0, 1'b0, 1'b1);
      step(4);
      checks++; if (acc !== 10'd640 || level !== 2'd1) begin errors++; $display("FAIL set_load: got acc=%0d lvl=%0d expected 640 1", acc, level); end
      cmd(1'b0, 1'b0, 1'b0, 1'b0);
      step(1);
      checks++; if (level !== 2'd2 || level_changed !== 1'b1) begin errors++; $display("FAIL set_level2: got lvl=%0d lc=%b expected 2 1", level, level_changed); end
      align();
      cmd(1'b0, 1'b1, 1'b1, 1'b0);
      step(40);
      checks++; if (acc !== 10'd600 || level !== 2'd2) begin errors++; $display("FAIL set_600: got acc=%0d lvl=%0d expected 600 2", acc, level); end
      cmd(1'b1, 1'b0, 1'b0, 1'b1);
      step(4);
      checks++; if (acc !== 10'd601) begin errors++; $display("FAIL set_ignored: got %0d expected 601", acc); end
   endtask

   task automatic test_mid_reset();
      cmd(1'b0, 1'b1, 1'b1, 1'b0);
      step(75 * 4);
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      step(4);
      checks++; if (acc !== 10'd300) begin errors++; $display("FAIL mid_pre: got %0d expected 300", acc); end
      step(2);
      #2 rst = 1'b1;
      #1;
      checks++; if (acc !== 10'd768 || level !== 2'd3 || level_changed !== 1'b0) begin errors++; $display("FAIL mid_reset: got acc=%0d lvl=%0d lc=%b expected 768 3 0", acc, level, level_changed); end
      #2 rst = 1'b0; ph = 0;
      step(3);
      checks++; if (acc !== 10'd768) begin errors++; $display("FAIL mid_tick_pre: got %0d expected 768", acc); end
      step(1);
      checks++; if (acc !== 10'd767) begin errors++; $display("FAIL mid_tick: got %0d expected 767", acc); end
   endtask

   task automatic test_hold_and_enable();
      cmd(1'b1, 1'b1, 1'b0, 1'b0);
      step(4);
      checks++; if (acc !== 10'd767) begin errors++; $display("FAIL incdec_hold: got %0d expected 767", acc); end
      cmd(1'b0, 1'b1, 1'b0, 1'b0);
      step(2);
      ena = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         checks++;
         if (acc !== 10'd767 || level !== 2'd3 || level_changed !== 1'b0) begin
            errors++;
            $display("FAIL freeze_%0d: got acc=%0d lvl=%0d lc=%b expected 767 3 0", i, acc, level, level_changed);
         end
      end
      ena = 1'b1;
      step(1);
      checks++; if (acc !== 10'd767) begin errors++; $display("FAIL resume_pre: got %0d expected 767", acc); end
      step(1);
      checks++; if (acc !== 10'd766) begin errors++; $display("FAIL resume_tick: got %0d expected 766", acc); end
   endtask

   initial begin
      test_reset();
      test_dec_hysteresis();
      test_inc_hysteresis();
      test_saturation();
      test_setval();
      test_mid_reset();
      test_hold_and_enable();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
